// File: rtl/store_drain_buffer_if.sv
// Commit-side store lanes and D-cache request channel of the store drain buffer.
// Define STORE_DRAIN_FWD_EN to add the store-to-load forwarding lookup signals.
interface store_drain_buffer_if #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [COMMIT_W-1:0]             in_valid;
  logic [COMMIT_W-1:0][ADDR_W-1:0] in_addr;
  logic [COMMIT_W-1:0][DATA_W-1:0] in_data;
  logic [CNT_W-1:0]                free_slots;
  logic                            empty;
  logic                            overflow_err;
  logic                            dc_req_valid;
  logic [ADDR_W-1:0]               dc_req_addr;
  logic [DATA_W-1:0]               dc_req_data;
  logic                            dc_req_ready;
`ifdef STORE_DRAIN_FWD_EN
  logic [ADDR_W-1:0]               fwd_addr;
  logic                            fwd_hit;
  logic [DATA_W-1:0]               fwd_data;

  modport slave (
    input  in_valid, in_addr, in_data, dc_req_ready, fwd_addr,
    output free_slots, empty, overflow_err,
           dc_req_valid, dc_req_addr, dc_req_data, fwd_hit, fwd_data
  );

  modport master (
    output in_valid, in_addr, in_data, dc_req_ready, fwd_addr,
    input  free_slots, empty, overflow_err,
           dc_req_valid, dc_req_addr, dc_req_data, fwd_hit, fwd_data
  );
`else
  modport slave (
    input  in_valid, in_addr, in_data, dc_req_ready,
    output free_slots, empty, overflow_err,
           dc_req_valid, dc_req_addr, dc_req_data
  );

  modport master (
    output in_valid, in_addr, in_data, dc_req_ready,
    input  free_slots, empty, overflow_err,
           dc_req_valid, dc_req_addr, dc_req_data
  );
`endif
endinterface

// File: rtl/store_drain_buffer.sv
// Circular FIFO that buffers committed stores and drains them oldest-first to the D-cache.
// Optional store-to-load forwarding lookup is enabled by defining STORE_DRAIN_FWD_EN.
module store_drain_buffer #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input logic                clk,
  input logic                rst,
  store_drain_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_acc;
  logic [PTR_W-1:0] wr_idx;
  logic             pop;

  // A pop this cycle does not free a slot for this cycle's pushes.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign pop        = (count_q != '0) && bus.dc_req_ready;

  always_comb begin
    mem_d      = mem_q;
    n_acc      = '0;
    overflow_d = overflow_q;
    wr_idx     = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (bus.in_valid[i]) begin
        if (n_acc < free_slots) begin
          wr_idx        = tail_q + PTR_W'(n_acc);
          mem_d[wr_idx] = '{addr: bus.in_addr[i], data: bus.in_data[i]};
          n_acc         = n_acc + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(n_acc);
    count_d = count_q + n_acc - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.free_slots   = free_slots;
  assign bus.empty        = (count_q == '0);
  assign bus.overflow_err = overflow_q;
  assign bus.dc_req_valid = (count_q != '0);
  assign bus.dc_req_addr  = mem_q[head_q].addr;
  assign bus.dc_req_data  = mem_q[head_q].data;

`ifdef STORE_DRAIN_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        fwd_idx = head_q + PTR_W'(k);
        if (mem_q[fwd_idx].addr == bus.fwd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_q[fwd_idx].data;
        end
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;
`endif
endmodule
